pc_sequencer: RTL

//  Parametrised registered fetch-PC sequencer: the PC register plus next-PC selection for the fetch stage.

---
 rtl/pc_pkg.sv | 19 +
 rtl/ras_stack.sv | 60 ++++++
 rtl/pc_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-PC sequencer: next-PC source encoding and
// default reset/interrupt vectors.
// Latency: n/a (types and constants only). Backpressure: n/a.
package pc_pkg;

  // Next-PC source, listed in priority order (HOLD wins over everything).
  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_INTR,
    SRC_POP,
    SRC_JMP,
    SRC_CALL,
    SRC_SEQ
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0020;
  localparam logic [31:0] DEF_INTR_VEC  = 32'h0000_0000;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: DEPTH x W LIFO with sticky overflow/underflow flags.
// Latency: push/pop take effect at the clock edge; top/empty/full are combinational from count.
// Backpressure: none; push when full is dropped (ovf set), pop when empty is ignored (unf set).
// Ports: clk, reset_n, push, pop, din (push data), top (current top entry),
//        empty, full (occupancy), ovf, unf (sticky error flags, cleared only by reset).
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  // Occupancy doubles as the write pointer; the read pointer is one below it,
  // wrapping mod DEPTH.
  assign wr_idx  = IDX_W'(count);
  assign top_idx = IDX_W'(count - CNT_W'(1));

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign top   = mem[top_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (push) begin
        if (full) ovf <= 1'b1;
        else      count <= count + CNT_W'(1);
      end else if (pop) begin
        if (empty) unf <= 1'b1;
        else       count <= count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read below the occupancy count.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC register with prioritised next-PC selection, RAS and latched interrupt.
// Latency: requests sampled at edge N appear on pc (and redirect/intr_ack) after edge N.
// Backpressure: stall holds pc and the RAS; only interrupt requests are latched meanwhile.
// Ports: clk, reset_n; stall, intr_req, intr_en, jump, call, ret, jump_addr (redirect inputs);
//        pc, redirect, intr_ack (registered); ras_empty, ras_full, ras_ovf, ras_unf (stack status).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              JADDR_W   = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0] INTR_VEC  = PC_W'(DEF_INTR_VEC),
  parameter int              PC_INC    = 1,
  parameter int              JMP_BIAS  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               intr_req,
  input  logic               intr_en,
  input  logic               jump,
  input  logic               call,
  input  logic               ret,
  input  logic [JADDR_W-1:0] jump_addr,
  output logic [PC_W-1:0]    pc,
  output logic               redirect,
  output logic               intr_ack,
  output logic               ras_empty,
  output logic               ras_full,
  output logic               ras_ovf,
  output logic               ras_unf
);

  pc_src_e          src;
  logic             pend;
  logic             take_i;
  logic [PC_W-1:0]  pc_seq;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_next;
  logic [PC_W-1:0]  push_dat;
  logic [PC_W-1:0]  ras_top;
  logic             push;
  logic             pop;

  assign take_i = (intr_req | pend) & intr_en & ~stall;
  assign pc_seq = pc + PC_W'(PC_INC);
  assign target = PC_W'(jump_addr);

  always_comb begin
    src = SRC_SEQ;
    if (stall)       src = SRC_HOLD;
    else if (take_i) src = SRC_INTR;
    else if (ret)    src = SRC_POP;
    else if (jump)   src = SRC_JMP;
    else if (call)   src = SRC_CALL;
  end

  // An interrupt pushes the current pc: that fetch is discarded and re-fetched on reti.
  assign push     = (src == SRC_INTR) || (src == SRC_CALL);
  assign pop      = (src == SRC_POP);
  assign push_dat = (src == SRC_INTR) ? pc : pc_seq;

  always_comb begin
    pc_next = pc_seq;
    case (src)
      SRC_HOLD: pc_next = pc;
      SRC_INTR: pc_next = INTR_VEC;
      SRC_POP:  pc_next = ras_empty ? RESET_VEC : ras_top;
      SRC_JMP:  pc_next = target - PC_W'(JMP_BIAS);
      SRC_CALL: pc_next = target;
      default:  pc_next = pc_seq;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_VEC;
      pend     <= 1'b0;
      redirect <= 1'b0;
      intr_ack <= 1'b0;
    end else begin
      pc       <= pc_next;
      redirect <= (src == SRC_INTR) || (src == SRC_POP) ||
                  (src == SRC_JMP)  || (src == SRC_CALL);
      intr_ack <= (src == SRC_INTR);
      // Single pending slot: cleared when taken, otherwise any request sets it.
      if (take_i)        pend <= 1'b0;
      else if (intr_req) pend <= 1'b1;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (push_dat),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full),
    .ovf     (ras_ovf),
    .unf     (ras_unf)
  );

endmodule
